xadac_issue_ctrl: RTL and testbench

- Initiator (master) end of the xadac request/response protocol; drives `xadac_if.mst` toward any xadac execution stage (vmacc, etc.).
- Accepts decoded vector commands from the core-side decode and assigns sequential IDs.
- Bounds in-flight requests, registers the request channel and buffers one response.
- Responses return in order and are checked against the expected ID.

---
 rtl/xadac_pkg.sv | 26 ++
 rtl/xadac_if.sv | 34 +++
 rtl/xadac_issue_skid.sv | 44 ++++
 rtl/xadac_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_xadac_issue_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadac_pkg.sv
// xadac shared widths and request/response bundles used by all
// initiators and execution stages.
package xadac_pkg;

    localparam int VectorWidth  = 128;
    localparam int ImmWidth     = 8;
    localparam int XLen         = 32;
    localparam int XadacIdWidth = 4;

    typedef logic [XadacIdWidth-1:0] xadac_id_t;

    typedef struct packed {
        xadac_id_t              id;
        logic [ImmWidth-1:0]    imm;
        logic [VectorWidth-1:0] vs1;
        logic [VectorWidth-1:0] vs2;
        logic [VectorWidth-1:0] vs3;
    } xadac_req_t;

    typedef struct packed {
        xadac_id_t              id;
        logic [VectorWidth-1:0] vd;
        logic [XLen-1:0]        rd;
    } xadac_resp_t;

endpackage

// File: rtl/xadac_if.sv
// xadac request/response channel between an initiator (mst) and an
// execution stage (slv).
interface xadac_if;
    import xadac_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    xadac_id_t              req_id;
    logic [ImmWidth-1:0]    req_imm;
    logic [VectorWidth-1:0] req_vs1;
    logic [VectorWidth-1:0] req_vs2;
    logic [VectorWidth-1:0] req_vs3;

    logic                   resp_valid;
    logic                   resp_ready;
    xadac_id_t              resp_id;
    logic [VectorWidth-1:0] resp_vd;
    logic [XLen-1:0]        resp_rd;

    modport mst (
        output req_valid, req_id, req_imm, req_vs1, req_vs2, req_vs3,
        input  req_ready,
        input  resp_valid, resp_id, resp_vd, resp_rd,
        output resp_ready
    );

    modport slv (
        input  req_valid, req_id, req_imm, req_vs1, req_vs2, req_vs3,
        output req_ready,
        output resp_valid, resp_id, resp_vd, resp_rd,
        input  resp_ready
    );

endinterface

// File: rtl/xadac_issue_skid.sv
// Generic one-entry valid/ready register; accepts a new word whenever
// empty or being drained in the same cycle.
module xadac_issue_skid #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/xadac_issue_ctrl.sv
// xadac initiator: sequential IDs, credit-bounded request register, one-entry response buffer.
// Build option: XADAC_ISSUE_ID_CHECK_EN enables in-order response ID checking on id_err.
module xadac_issue_ctrl
    import xadac_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter int IdWidth        = XadacIdWidth
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ImmWidth-1:0]    cmd_imm,
    input  logic [VectorWidth-1:0] cmd_vs1,
    input  logic [VectorWidth-1:0] cmd_vs2,
    input  logic [VectorWidth-1:0] cmd_vs3,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IdWidth-1:0]     res_id,
    output logic [VectorWidth-1:0] res_vd,
    output logic [XLen-1:0]        res_rd,
    output logic                   id_err,
    output logic                   busy,
    xadac_if.mst                   mst
);

    localparam int CntW = $clog2(MaxOutstanding + 2);

    logic [IdWidth-1:0] next_id_q, next_id_d;
    logic [CntW-1:0]    outstanding_q, outstanding_d;
    logic               req_hs, resp_hs, cmd_hs;
    logic               credit_ok, stage_ready;
    xadac_req_t         cmd_req, req_q;
    xadac_resp_t        resp_in, resp_q;

    assign req_hs  = mst.req_valid && mst.req_ready;
    assign resp_hs = mst.resp_valid && mst.resp_ready;

    // A response retiring this cycle frees its credit immediately.
    assign credit_ok = (outstanding_q + CntW'(mst.req_valid))
                     < (CntW'(MaxOutstanding) + CntW'(resp_hs));
    assign cmd_ready = stage_ready && credit_ok;
    assign cmd_hs    = cmd_valid && cmd_ready;

    assign cmd_req = '{id: next_id_q, imm: cmd_imm,
                       vs1: cmd_vs1, vs2: cmd_vs2, vs3: cmd_vs3};

    xadac_issue_skid #(
        .Width($bits(xadac_req_t))
    ) u_req (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid_i (cmd_valid && credit_ok),
        .in_ready_o (stage_ready),
        .in_data_i  (cmd_req),
        .out_valid_o(mst.req_valid),
        .out_ready_i(mst.req_ready),
        .out_data_o (req_q)
    );

    assign mst.req_id  = req_q.id;
    assign mst.req_imm = req_q.imm;
    assign mst.req_vs1 = req_q.vs1;
    assign mst.req_vs2 = req_q.vs2;
    assign mst.req_vs3 = req_q.vs3;

    assign resp_in = '{id: mst.resp_id, vd: mst.resp_vd, rd: mst.resp_rd};

    xadac_issue_skid #(
        .Width($bits(xadac_resp_t))
    ) u_resp (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid_i (mst.resp_valid),
        .in_ready_o (mst.resp_ready),
        .in_data_i  (resp_in),
        .out_valid_o(res_valid),
        .out_ready_i(res_ready),
        .out_data_o (resp_q)
    );

    assign res_id = resp_q.id;
    assign res_vd = resp_q.vd;
    assign res_rd = resp_q.rd;

    always_comb begin
        next_id_d     = next_id_q;
        outstanding_d = outstanding_q;
        if (cmd_hs) begin
            next_id_d = next_id_q + IdWidth'(1);
        end
        if (req_hs && !resp_hs) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!req_hs && resp_hs && outstanding_q != '0) begin
            outstanding_d = outstanding_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            next_id_q     <= '0;
            outstanding_q <= '0;
        end else begin
            next_id_q     <= next_id_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign busy = (outstanding_q != '0) || mst.req_valid;

`ifdef XADAC_ISSUE_ID_CHECK_EN
    logic [IdWidth-1:0] exp_id_q, exp_id_d;
    logic               id_err_q, id_err_d;
    logic               unexpected;

    // Zero-latency answers to the request handshaking now are legal.
    assign unexpected = resp_hs && !req_hs && (outstanding_q == '0);

    always_comb begin
        exp_id_d = exp_id_q;
        id_err_d = id_err_q;
        if (resp_hs) begin
            exp_id_d = exp_id_q + IdWidth'(1);
            if (mst.resp_id != exp_id_q || unexpected) begin
                id_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_id_q <= '0;
            id_err_q <= 1'b0;
        end else begin
            exp_id_q <= exp_id_d;
            id_err_q <= id_err_d;
        end
    end

    assign id_err = id_err_q;
`else
    assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_xadac_issue_ctrl.sv
// Bench for xadac_issue_ctrl: directed protocol steps plus a randomized
// phase scored against queue-based transaction and credit models.
`define CHK(tag, o, e) chk(tag, 512'(o), 512'(e))

module tb_xadac_issue_ctrl;
    import xadac_pkg::*;

    localparam int MaxOut = 4;
`ifdef XADAC_ISSUE_ID_CHECK_EN
    localparam logic IdChk = 1'b1;
`else
    localparam logic IdChk = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   cmd_valid, cmd_ready;
    logic [ImmWidth-1:0]    cmd_imm;
    logic [VectorWidth-1:0] cmd_vs1, cmd_vs2, cmd_vs3;
    logic                   res_valid, res_ready;
    xadac_id_t              res_id;
    logic [VectorWidth-1:0] res_vd;
    logic [XLen-1:0]        res_rd;
    logic                   id_err, busy;

    logic      zl, s_req_ready, s_resp_valid;
    xadac_id_t s_resp_id;

    xadac_req_t cmdq[$];
    xadac_id_t  pend[$];
    xadac_id_t  resq[$];
    xadac_id_t  m_next;
    int n_chk, n_pass, n_req_hs;

    logic       mon_hold;
    xadac_req_t mon_prev, mon_cur;

    always #5 clk = ~clk;

    function automatic logic [VectorWidth-1:0] vd_of(xadac_id_t id);
        return {4{28'hA5A5A5A, id}};
    endfunction

    function automatic logic [XLen-1:0] rd_of(xadac_id_t id);
        return {28'h00C0DE0, id};
    endfunction

    xadac_if bus ();

    assign bus.req_ready  = s_req_ready;
    assign bus.resp_valid = zl ? bus.req_valid : s_resp_valid;
    assign bus.resp_id    = zl ? bus.req_id : s_resp_id;
    assign bus.resp_vd    = vd_of(bus.resp_id);
    assign bus.resp_rd    = rd_of(bus.resp_id);

    xadac_issue_ctrl #(.MaxOutstanding(MaxOut), .IdWidth(XadacIdWidth)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_imm  (cmd_imm),
        .cmd_vs1  (cmd_vs1),
        .cmd_vs2  (cmd_vs2),
        .cmd_vs3  (cmd_vs3),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_vd   (res_vd),
        .res_rd   (res_rd),
        .id_err   (id_err),
        .busy     (busy),
        .mst      (bus.mst)
    );

    assign mon_cur = '{id: bus.req_id, imm: bus.req_imm, vs1: bus.req_vs1,
                       vs2: bus.req_vs2, vs3: bus.req_vs3};

    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            mon_hold = 1'b0;
        end else begin
            if (mon_hold) begin
                n_chk++;
                if (bus.req_valid === 1'b1 && mon_cur === mon_prev) n_pass++;
                else $error("FAIL req_stable: observed %0h expected %0h",
                            mon_cur, mon_prev);
            end
            mon_hold = bus.req_valid && !bus.req_ready;
            mon_prev = mon_cur;
        end
    end

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs are set at posedge+1; settle, score this cycle, advance.
    task automatic step();
        logic ch, rq, rs, rh;
        int pend_n;
        xadac_req_t e, o;
        xadac_id_t r;
        #1;
        ch = cmd_valid && cmd_ready;
        rq = bus.req_valid && bus.req_ready;
        rs = bus.resp_valid && bus.resp_ready;
        rh = res_valid && res_ready;
        pend_n = pend.size();
        `CHK("cmd_ready", cmd_ready, (!bus.req_valid || bus.req_ready) &&
             (pend_n + int'(bus.req_valid) - int'(rs) < MaxOut));
        `CHK("resp_ready", bus.resp_ready, !res_valid || res_ready);
        `CHK("busy", busy, (pend_n != 0) || bus.req_valid);
        if (rq) begin
            e = (cmdq.size() != 0) ? cmdq.pop_front() : '1;
            o = '{id: bus.req_id, imm: bus.req_imm, vs1: bus.req_vs1,
                  vs2: bus.req_vs2, vs3: bus.req_vs3};
            `CHK("req_payload", o, e);
            pend.push_back(bus.req_id);
            n_req_hs++;
        end
        if (rh) begin
            r = (resq.size() != 0) ? resq.pop_front() : ~res_id;
            `CHK("res_payload", {res_id, res_vd, res_rd},
                 {r, vd_of(r), rd_of(r)});
        end
        if (rs) begin
            resq.push_back(bus.resp_id);
            if (pend.size() != 0) void'(pend.pop_front());
        end
        if (ch) begin
            e = '{id: m_next, imm: cmd_imm, vs1: cmd_vs1,
                  vs2: cmd_vs2, vs3: cmd_vs3};
            cmdq.push_back(e);
            m_next++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_imm = '0;
        cmd_vs1 = '0; cmd_vs2 = '0; cmd_vs3 = '0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_id = '0;
        zl = 1'b0; res_ready = 1'b0;
        #1;
        `CHK("rst_req_valid", bus.req_valid, 0);
        `CHK("rst_req", {bus.req_id, bus.req_imm, bus.req_vs1,
                         bus.req_vs2, bus.req_vs3}, 0);
        `CHK("rst_res_valid", res_valid, 0);
        `CHK("rst_res", {res_id, res_vd, res_rd}, 0);
        `CHK("rst_id_err", id_err, 0);
        `CHK("rst_busy", busy, 0);
        cmdq.delete(); pend.delete(); resq.delete();
        m_next = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic run_b2b(int n);
        zl = 1'b1; s_req_ready = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b1;
            cmd_imm = ImmWidth'(i);
            cmd_vs1 = VectorWidth'(i * 3);
            step();
            `CHK("b2b_req_valid", bus.req_valid, 1);
            `CHK("b2b_req_id", bus.req_id, i % 16);
            if (i > 0) begin
                `CHK("b2b_res_valid", res_valid, 1);
                `CHK("b2b_res_id", res_id, (i - 1) % 16);
            end
        end
        cmd_valid = 1'b0;
        step();
        `CHK("b2b_tail_req_valid", bus.req_valid, 0);
        `CHK("b2b_tail_res_id", res_id, (n - 1) % 16);
        `CHK("b2b_tail_res_valid", res_valid, 1);
        step();
        `CHK("b2b_idle_res_valid", res_valid, 0);
        `CHK("b2b_idle_busy", busy, 0);
        `CHK("b2b_id_err", id_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        n_chk = 0; n_pass = 0; n_req_hs = 0;
        mon_hold = 1'b0;
        rstn = 1'b1;
        #2;
        do_reset();

        // Zero-latency slave, full throughput.
        run_b2b(6);

        // ID wrap: 17th command reuses id 0.
        do_reset();
        run_b2b(17);

        // Credit limit with no responses.
        do_reset();
        s_req_ready = 1'b1; res_ready = 1'b1;
        base = n_req_hs;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_imm = ImmWidth'($urandom);
            cmd_vs1 = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        `CHK("credit_hs", n_req_hs - base, 4);
        #1;
        `CHK("credit_block", cmd_ready, 0);
        s_resp_valid = 1'b1; s_resp_id = '0;
        #1;
        `CHK("credit_release", cmd_ready, 1);
        step();
        s_resp_valid = 1'b0; cmd_valid = 1'b0;

        // Backpressure holds the request register.
        do_reset();
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_imm = ImmWidth'(5);
        cmd_vs1 = {16{8'hA5}}; cmd_vs2 = ~cmd_vs1; cmd_vs3 = {8{16'h5AA5}};
        step();
        cmd_imm = ImmWidth'(7); cmd_vs1 = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            `CHK("bp_valid", bus.req_valid, 1);
            `CHK("bp_hold", {bus.req_id, bus.req_imm, bus.req_vs1},
                 {4'd0, 8'd5, {16{8'hA5}}});
        end
        base = n_req_hs;
        cmd_valid = 1'b0; s_req_ready = 1'b1;
        step();
        `CHK("bp_one_hs", n_req_hs - base, 1);
        `CHK("bp_drop", bus.req_valid, 0);

        // Wrong response id.
        do_reset();
        s_req_ready = 1'b1; res_ready = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            s_resp_valid = 1'b1; s_resp_id = pend[0];
            step();
        end
        `CHK("iderr_clean", id_err, 0);
        s_resp_id = 4'd3;
        step();
        s_resp_valid = 1'b0;
        `CHK("iderr_set", id_err, IdChk);
        repeat (3) step();
        `CHK("iderr_sticky", id_err, IdChk);

        // Response with nothing outstanding.
        do_reset();
        res_ready = 1'b1;
        s_resp_valid = 1'b1; s_resp_id = '0;
        step();
        s_resp_valid = 1'b0;
        `CHK("unexp_err", id_err, IdChk);
        `CHK("unexp_res", {res_valid, res_id}, {1'b1, 4'd0});
        `CHK("unexp_busy", busy, 0);

        // Reset mid-stream with two outstanding and one pending.
        do_reset();
        s_req_ready = 1'b1; res_ready = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) step();
        `CHK("mid_pre", {bus.req_valid, 8'(pend.size())}, {1'b1, 8'd2});
        do_reset();
        s_req_ready = 1'b1;
        cmd_valid = 1'b1; cmd_imm = ImmWidth'(9);
        step();
        cmd_valid = 1'b0;
        `CHK("mid_first_id", {bus.req_valid, bus.req_id}, {1'b1, 4'd0});

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cmd_valid = 1'($urandom);
            cmd_imm = ImmWidth'($urandom);
            cmd_vs1 = {$urandom, $urandom, $urandom, $urandom};
            cmd_vs2 = {$urandom, $urandom, $urandom, $urandom};
            cmd_vs3 = {$urandom, $urandom, $urandom, $urandom};
            s_req_ready = ($urandom % 4) != 0;
            res_ready = ($urandom % 3) != 0;
            s_resp_valid = (pend.size() != 0) && (($urandom % 2) != 0);
            s_resp_id = (pend.size() != 0) ? pend[0] : '0;
            step();
        end
        cmd_valid = 1'b0; s_req_ready = 1'b1; res_ready = 1'b1;
        for (int k = 0; k < 60 && (pend.size() != 0 || cmdq.size() != 0 ||
             resq.size() != 0 || busy || res_valid); k++) begin
            s_resp_valid = pend.size() != 0;
            s_resp_id = (pend.size() != 0) ? pend[0] : '0;
            step();
        end
        s_resp_valid = 1'b0;
        `CHK("rand_drained", {8'(cmdq.size()), 8'(pend.size()),
                              8'(resq.size())}, 0);
        `CHK("rand_idle", {busy, res_valid}, 0);
        `CHK("rand_id_err", id_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
